// File: rtl/hyperbus_arbiter.sv
// Two-requester round-robin arbiter in front of a Hyperbus controller.
// Define HYPERBUS_ARB_TIMEOUT_EN to abort transfers that stall for TIMEOUT cycles.
module hyperbus_arbiter #(
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int TURN_CYCLES     = 2,
  parameter int TIMEOUT         = 255
) (
  input  logic                         hbus_clk,
  input  logic                         hbus_rst_n,
  output logic [HBUS_ADDR_WIDTH-1:0]   hbus_adr_o,
  output logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_o,
  input  logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_i,
  output logic                         hbus_rrq,
  output logic                         hbus_wrq,
  input  logic                         hbus_ready,
  input  logic                         hbus_valid,
  input  logic                         hbus_busy,
  input  logic [1:0]                   m_rrq,
  input  logic [1:0]                   m_wrq,
  output logic [1:0]                   m_gnt,
  output logic [1:0]                   m_ready,
  output logic [1:0]                   m_valid,
  output logic [1:0]                   m_done,
  output logic [1:0]                   m_err,
  input  logic [2*HBUS_ADDR_WIDTH-1:0] m_adr_i,
  input  logic [15:0]                  m_len_i,
  input  logic [2*HBUS_DATA_WIDTH-1:0] m_dat_i,
  output logic [HBUS_DATA_WIDTH-1:0]   m_dat_o
);

  localparam int AW = HBUS_ADDR_WIDTH;
  localparam int DW = HBUS_DATA_WIDTH;
  localparam int TW = (TURN_CYCLES > 2) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST =
    TW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    TURN
  } state_t;

  state_t          state, state_n;
  logic            sel, sel_n;
  logic            last, last_n;
  logic            rd, rd_n;
  logic [7:0]      cnt, cnt_n;
  logic [AW-1:0]   adr_n;
  logic            rrq_n, wrq_n;
  logic [1:0]      gnt_n, done_n;
  logic [TW-1:0]   turn, turn_n;
  logic [1:0]      req;
  logic            win;
  logic            xfer;
  logic            beat;
  logic            tmo;

  assign req  = m_rrq | m_wrq;
  // On contention the requester that was not granted last wins.
  assign win  = (req == 2'b11) ? ~last : req[1];
  assign xfer = (state == XFER);
  assign beat = rd ? hbus_valid : hbus_ready;

`ifdef HYPERBUS_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall, stall_n;
  logic [1:0]    err_q, err_n;
  assign tmo   = (stall == SW'(TIMEOUT)) && !beat;
  assign m_err = err_q;
`else
  assign tmo   = 1'b0;
  assign m_err = 2'b00;
`endif

  always_comb begin
    state_n = state;
    sel_n   = sel;
    last_n  = last;
    rd_n    = rd;
    cnt_n   = cnt;
    adr_n   = hbus_adr_o;
    rrq_n   = hbus_rrq;
    wrq_n   = hbus_wrq;
    gnt_n   = m_gnt;
    done_n  = 2'b00;
    turn_n  = turn;
`ifdef HYPERBUS_ARB_TIMEOUT_EN
    stall_n = stall;
    err_n   = 2'b00;
`endif
    unique case (state)
      IDLE: begin
        if (!hbus_busy && |req) begin
          state_n = XFER;
          sel_n   = win;
          last_n  = win;
          rd_n    = m_rrq[win];
          cnt_n   = win ? m_len_i[15:8] : m_len_i[7:0];
          adr_n   = win ? m_adr_i[2*AW-1:AW] : m_adr_i[AW-1:0];
          rrq_n   = m_rrq[win];
          wrq_n   = !m_rrq[win];
          gnt_n   = win ? 2'b10 : 2'b01;
`ifdef HYPERBUS_ARB_TIMEOUT_EN
          stall_n = '0;
`endif
        end
      end
      XFER: begin
        if (beat || tmo) begin
          cnt_n = cnt - 8'd1;
          if (tmo || cnt == 8'd0) begin
            state_n = TURN;
            cnt_n   = 8'd0;
            rrq_n   = 1'b0;
            wrq_n   = 1'b0;
            gnt_n   = 2'b00;
            turn_n  = '0;
            if (!tmo) begin
              done_n = m_gnt;
            end
`ifdef HYPERBUS_ARB_TIMEOUT_EN
            else begin
              err_n = m_gnt;
            end
`endif
          end
`ifdef HYPERBUS_ARB_TIMEOUT_EN
          stall_n = '0;
        end else begin
          stall_n = stall + 1'b1;
`endif
        end
      end
      TURN: begin
        if (turn >= TLAST && !hbus_busy) begin
          state_n = IDLE;
        end else if (turn < TLAST) begin
          turn_n = turn + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge hbus_clk) begin
    if (!hbus_rst_n) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last       <= 1'b1;
      rd         <= 1'b0;
      cnt        <= 8'd0;
      hbus_adr_o <= '0;
      hbus_rrq   <= 1'b0;
      hbus_wrq   <= 1'b0;
      m_gnt      <= 2'b00;
      m_done     <= 2'b00;
      turn       <= '0;
`ifdef HYPERBUS_ARB_TIMEOUT_EN
      stall      <= '0;
      err_q      <= 2'b00;
`endif
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      last       <= last_n;
      rd         <= rd_n;
      cnt        <= cnt_n;
      hbus_adr_o <= adr_n;
      hbus_rrq   <= rrq_n;
      hbus_wrq   <= wrq_n;
      m_gnt      <= gnt_n;
      m_done     <= done_n;
      turn       <= turn_n;
`ifdef HYPERBUS_ARB_TIMEOUT_EN
      stall      <= stall_n;
      err_q      <= err_n;
`endif
    end
  end

  // Beat handshakes and data are steered combinationally to the owner.
  assign m_valid = (xfer && rd) ?
    {sel & hbus_valid, ~sel & hbus_valid} : 2'b00;
  assign m_ready = (xfer && !rd) ?
    {sel & hbus_ready, ~sel & hbus_ready} : 2'b00;
  assign m_dat_o = (xfer && rd) ? hbus_dat_i : '0;
  assign hbus_dat_o = (xfer && !rd) ?
    (sel ? m_dat_i[2*DW-1:DW] : m_dat_i[DW-1:0]) : '0;

endmodule
